hex_display_top: RTL and testbench

Board-level top that shows the 16-bit switch value as four hexadecimal digits on a common-anode, time-multiplexed 4-digit seven-segment display. It contains a scan prescaler, a 2-bit digit scanner, a nibble multiplexer and a hex-to-segment decoder. `clk` is the 100 MHz board clock and `BTNY` is the reset pushbutton. The block is the root of the FPGA design and has no parent.

---
 rtl/hex_display_top.sv | 99 +++++++++
 tb/tb_hex_display_top.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hex_display_top.sv
// hex_display_top
//   Shows the 16-bit switch value as four hex digits on a common-anode,
//   time-multiplexed 4-digit seven-segment display.
//   A prescaler holds each digit lit for SCAN_DIV clocks. A 2-bit scanner
//   then walks the digits right to left (idx 0..3). AN and SEG are
//   registered, so they follow idx by one clock.
//
// Parameters
//   SCAN_DIV  clocks per digit (2..2^20)
// Ports
//   clk   in   system clock, rising edge
//   BTNY  in   synchronous active-high reset (blanks the display)
//   SW    in   [15:0] value to display; SW[3:0] drives the rightmost digit
//   SEG   out  [7:0] active-low cathodes, {dp,g,f,e,d,c,b,a}
//   AN    out  [3:0] active-low anodes, AN[0] is the rightmost digit
module hex_display_top #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        BTNY,
  input  logic [15:0] SW,
  output logic [7:0]  SEG,
  output logic [3:0]  AN
);

  localparam logic [19:0] CNT_LAST = 20'(SCAN_DIV - 1);

  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  nibble;

  // Active-low segment code; dp (bit 7) is always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d  = cnt_q + 20'd1;
    idx_d  = idx_q;
    an_d   = 4'b1110;
    nibble = SW[3:0];

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Outputs are built from the pre-edge idx and the live switches, so
    // a switch change shows on the lit digit at the very next edge.
    case (idx_q)
      2'd0: begin an_d = 4'b1110; nibble = SW[3:0];   end
      2'd1: begin an_d = 4'b1101; nibble = SW[7:4];   end
      2'd2: begin an_d = 4'b1011; nibble = SW[11:8];  end
      default: begin an_d = 4'b0111; nibble = SW[15:12]; end
    endcase

    seg_d = hex_to_seg(nibble);
  end

  // Register stage: reset takes priority over a terminal count on the same edge.
  always_ff @(posedge clk) begin
    if (BTNY) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= 8'hFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_hex_display_top.sv
module tb_hex_display_top;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        BTNY;
  logic [15:0] SW;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb_q[$];

  // Reference scanner state, advanced once per driven cycle.
  int mdl_cnt = 0;
  int mdl_idx = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [3:0] an_tab  [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  hex_display_top #(.SCAN_DIV(DIV)) dut (
    .clk  (clk),
    .BTNY (BTNY),
    .SW   (SW),
    .SEG  (SEG),
    .AN   (AN)
  );

  always #5 clk = ~clk;

  // Drive one cycle. When lit=1 the literal expectation is pushed, otherwise
  // the reference model's prediction is pushed. Compared after the edge.
  task automatic step(input logic btn, input logic [15:0] sw, input logic lit,
                      input logic [3:0] lan, input logic [7:0] lseg, input string tag);
    exp_t e;
    exp_t got;
    logic [3:0] nib;
    BTNY = btn;
    SW   = sw;
    if (btn) begin
      e.an = 4'b1111;
      e.seg = 8'hFF;
      mdl_cnt = 0;
      mdl_idx = 0;
    end else begin
      nib = 4'((sw >> (4 * mdl_idx)) & 16'hF);
      e.an = an_tab[mdl_idx];
      e.seg = seg_tab[nib];
      if (mdl_cnt == DIV - 1) begin
        mdl_cnt = 0;
        mdl_idx = (mdl_idx + 1) % 4;
      end else begin
        mdl_cnt = mdl_cnt + 1;
      end
    end
    if (lit) begin
      e.an = lan;
      e.seg = lseg;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checks++;
    assert (AN === got.an) else begin
      failures++;
      $error("FAIL %s AN observed=%b expected=%b", tag, AN, got.an);
    end
    checks++;
    assert (SEG === got.seg) else begin
      failures++;
      $error("FAIL %s SEG observed=%h expected=%h", tag, SEG, got.seg);
    end
    if (!btn) begin
      checks++;
      assert ($countones(~AN) == 1) else begin
        failures++;
        $error("FAIL %s onehot AN observed=%b expected=one zero", tag, AN);
      end
      checks++;
      assert (SEG[7] === 1'b1) else begin
        failures++;
        $error("FAIL %s dp observed=%b expected=1", tag, SEG[7]);
      end
    end
  endtask

  initial begin
    logic [3:0] an_abcd  [4];
    logic [7:0] seg_abcd [4];
    an_abcd  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_abcd = '{8'hA1, 8'hC6, 8'h83, 8'h88};

    // Reset dwell
    for (int i = 0; i < 3; i++) step(1'b1, 16'hABCD, 1'b1, 4'b1111, 8'hFF, "reset_dwell");

    // Scan sequence: two full frames
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < DIV; c++)
          step(1'b0, 16'hABCD, 1'b1, an_abcd[d], seg_abcd[d], "scan");

    // Live update while digit 1 is lit
    for (int c = 0; c < DIV; c++) step(1'b0, 16'hABCD, 1'b1, 4'b1110, 8'hA1, "live_d0");
    for (int c = 0; c < 2; c++)   step(1'b0, 16'hABCD, 1'b1, 4'b1101, 8'hC6, "live_d1_old");
    for (int c = 0; c < 2; c++)   step(1'b0, 16'hAB3D, 1'b1, 4'b1101, 8'hB0, "live_d1_new");
    for (int c = 0; c < 2; c++)   step(1'b0, 16'hAB3D, 1'b1, 4'b1011, 8'h83, "live_d2");

    // Mid-scan reset during digit 2, then full-length digit 0 dwell
    step(1'b1, 16'hABCD, 1'b1, 4'b1111, 8'hFF, "midscan_reset");
    for (int c = 0; c < DIV; c++) step(1'b0, 16'hABCD, 1'b1, 4'b1110, 8'hA1, "post_reset_d0");
    step(1'b0, 16'hABCD, 1'b1, 4'b1101, 8'hC6, "post_reset_d1");

    // Decoder sweep: all digits equal, one full frame each
    for (int v = 0; v < 16; v++)
      for (int c = 0; c < 4 * DIV; c++)
        step(1'b0, {4{4'(v)}}, 1'b0, 4'h0, 8'h0, "decode_sweep");

    // Spot checks from a fresh scan start
    step(1'b1, 16'h8888, 1'b1, 4'b1111, 8'hFF, "spot_reset");
    step(1'b0, 16'h8888, 1'b1, 4'b1110, 8'h80, "spot_8888");
    step(1'b0, 16'h0000, 1'b1, 4'b1110, 8'hC0, "spot_0000");

    // Random switches over 10 frames
    for (int c = 0; c < 10 * 4 * DIV; c++)
      step(1'b0, 16'($urandom), 1'b0, 4'h0, 8'h0, "random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
